// File: rtl/data_mem_resp_model_if.sv
// Ibex data-port bundle (req/gnt/rvalid) between the core side
// and the memory responder.
interface data_mem_resp_model_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i,
    output data_we_i,
    output data_be_i,
    output data_addr_i,
    output data_wdata_i,
    input  data_gnt_o,
    input  data_rvalid_o,
    input  data_rdata_o,
    input  data_err_o
  );

  modport slave (
    input  data_req_i,
    input  data_we_i,
    input  data_be_i,
    input  data_addr_i,
    input  data_wdata_i,
    output data_gnt_o,
    output data_rvalid_o,
    output data_rdata_o,
    output data_err_o
  );
endinterface

// File: rtl/data_mem_resp_model.sv
// Data-memory responder for the Ibex data port: delayed/stallable
// grant, fixed-latency in-order responses, byte writes, error window.
module data_mem_resp_model #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RESP_LAT        = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_BASE        = 32'hFFFF_F000,
  parameter logic [31:0] ERR_LIMIT       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  data_mem_resp_model_if.slave bus,
  input  logic        stall_i,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] err_count_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WW = $clog2(GNT_DELAY + 1) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } resp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [WW-1:0] wait_cnt;
  logic [OW-1:0] outstanding;
  logic          wait_ok;
  logic          room;
  logic          gnt;
  logic          hit_err;
  logic          in_win;
  logic          off_end;
  logic [AW-1:0] idx;
  logic          rvalid;
  resp_t         in_resp;
  resp_t         tail_in;
  resp_t         pipe [RESP_LAT];

  assign wait_ok = wait_cnt >= WW'(GNT_DELAY);
  assign room    = outstanding < OW'(MAX_OUTSTANDING);
  assign gnt     = bus.data_req_i & ~stall_i & ~rst & wait_ok & room;

  // 33-bit compares keep an all-ones limit from being a constant test
  assign in_win  = ({1'b0, bus.data_addr_i} >= {1'b0, ERR_BASE}) &&
                   ({1'b0, bus.data_addr_i} <= {1'b0, ERR_LIMIT});
  assign off_end = {2'b00, bus.data_addr_i[31:2]} >= DEPTH_WORDS;
  assign hit_err = in_win | off_end;
  assign idx     = bus.data_addr_i[AW+1:2];

  assign rvalid            = pipe[RESP_LAT-1].v;
  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = rvalid;
  assign bus.data_err_o    = pipe[RESP_LAT-1].e;
  assign bus.data_rdata_o  = pipe[RESP_LAT-1].d;

  always_comb begin
    in_resp = '0;
    if (gnt) begin
      in_resp.v = 1'b1;
      in_resp.e = hit_err;
      if (!bus.data_we_i && !hit_err) begin
        in_resp.d = mem[idx];
      end
    end
  end

  if (RESP_LAT == 1) begin : g_tail1
    assign tail_in = in_resp;
  end else begin : g_tailn
    assign tail_in = pipe[RESP_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (gnt && bus.data_we_i && !hit_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESP_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= in_resp;
      for (int i = 1; i < RESP_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // stall holds the count so a pending request keeps its earned delay
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!bus.data_req_i || gnt) begin
      wait_cnt <= '0;
    end else if (!wait_ok) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OW'(gnt) - OW'(rvalid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_o  <= '0;
      wr_count_o  <= '0;
      err_count_o <= '0;
    end else begin
      rd_count_o  <= rd_count_o + 32'(gnt & ~bus.data_we_i);
      wr_count_o  <= wr_count_o + 32'(gnt & bus.data_we_i);
      err_count_o <= err_count_o + 32'(tail_in.v & tail_in.e);
    end
  end

  a_out_limit: assert property (@(posedge clk) disable iff (rst)
    outstanding <= OW'(MAX_OUTSTANDING));

  a_rv_owned: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_data_mem_resp_model.sv
// Scoreboard bench for data_mem_resp_model: three configurations,
// directed transactions with hand-computed expected responses.
module tb_data_mem_resp_model;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  logic        clk;
  int          cyc;
  int          checks;
  int          fails;
  logic [2:0]  rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  stall;
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  err;
  logic [31:0] rdata [3];
  logic [31:0] rdc   [3];
  logic [31:0] wrc   [3];
  logic [31:0] erc   [3];
  exp_t        sbq   [3][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    localparam int unsigned GD  = (g == 1) ? 2 : 0;

    data_mem_resp_model_if bus ();

    assign bus.data_req_i   = req[g];
    assign bus.data_we_i    = we[g];
    assign bus.data_be_i    = be[g];
    assign bus.data_addr_i  = addr[g];
    assign bus.data_wdata_i = wdata[g];
    assign gnt[g]           = bus.data_gnt_o;
    assign rvalid[g]        = bus.data_rvalid_o;
    assign err[g]           = bus.data_err_o;
    assign rdata[g]         = bus.data_rdata_o;

    data_mem_resp_model #(
      .DEPTH_WORDS     (1024),
      .GNT_DELAY       (GD),
      .RESP_LAT        (LAT),
      .MAX_OUTSTANDING (2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .bus         (bus),
      .stall_i     (stall[g]),
      .rd_count_o  (rdc[g]),
      .wr_count_o  (wrc[g]),
      .err_count_o (erc[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (!rst[g] && rvalid[g]) begin
        if (sbq[g].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rvalid_unexpected: inst %0d got rvalid want none (cyc %0d)",
                   g, cyc);
        end else begin
          e = sbq[g].pop_front();
          chk($sformatf("rdata_i%0d", g), rdata[g], e.d);
          chk($sformatf("err_i%0d", g), 32'(err[g]), 32'(e.e));
          chk($sformatf("latency_i%0d", g), 32'(cyc - e.cyc), LAT);
        end
      end
    end
  end

  task automatic idle(input int g);
    req[g]   = 1'b0;
    we[g]    = 1'b0;
    be[g]    = 4'h0;
    addr[g]  = '0;
    wdata[g] = '0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Holds req until granted; leaves req high so calls chain back-to-back
  task automatic xact(input int g, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee,
                      input int exp_wait);
    bit granted;
    granted  = 1'b0;
    req[g]   = 1'b1;
    we[g]    = w;
    be[g]    = b;
    addr[g]  = a;
    wdata[g] = wd;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (gnt[g]) begin
        sbq[g].push_back('{d: ed, e: ee, cyc: cyc});
        chk($sformatf("gnt_wait_i%0d_a%h", g, a), 32'(n), 32'(exp_wait));
        granted = 1'b1;
        break;
      end
    end
    if (!granted) begin
      checks++;
      fails++;
      $display("FAIL gnt_timeout: inst %0d addr %h got no gnt want gnt", g, a);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 3'b111;
    stall  = 3'b000;
    for (int i = 0; i < 3; i++) idle(i);
    repeat (2) @(posedge clk);
    #1;
    req = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("gnt_in_reset", 32'(gnt[i]), 0);
      chk("rvalid_reset", 32'(rvalid[i]), 0);
      chk("rdata_reset", rdata[i], 0);
      chk("rd_count_reset", rdc[i], 0);
    end
    @(posedge clk);
    #1;
    req = 3'b000;
    rst = 3'b000;

    // defaults: write then immediate read of the same word
    xact(0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    idle(0);
    drain();
    chk("rd_count_basic", rdc[0], 1);
    chk("wr_count_basic", wrc[0], 1);

    // byte enables, including the be=0000 no-op write
    xact(0, 1'b1, 4'hF, 32'h200, 32'h1122_3344, 32'h0, 1'b0, 0);
    xact(0, 1'b1, 4'b0101, 32'h200, 32'hAABB_CCDD, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 4'hF, 32'h200, 32'h0, 32'h11BB_33DD, 1'b0, 0);
    xact(0, 1'b1, 4'b0000, 32'h200, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 4'hF, 32'h200, 32'h0, 32'h11BB_33DD, 1'b0, 0);
    idle(0);

    // error window and off-the-end write (aliases word 0 if unguarded)
    xact(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    xact(0, 1'b1, 4'hF, 32'hFFC, 32'h1234_5678, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 4'hF, 32'hFFFF_F004, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b1, 4'hF, 32'h1000, 32'h5555_5555, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    xact(0, 1'b0, 4'hF, 32'hFFC, 32'h0, 32'h1234_5678, 1'b0, 0);
    idle(0);
    drain();
    chk("err_count", erc[0], 2);
    chk("rd_count_mix", rdc[0], 6);
    chk("wr_count_mix", wrc[0], 7);

    // stall for 5 cycles, grant right after it drops
    stall[0] = 1'b1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        stall[0] = 1'b0;
      end
    join_none
    xact(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    idle(0);
    drain();
    chk("rd_count_stall", rdc[0], 7);

    // GNT_DELAY=2, RESP_LAT=3: held req, grant every 3rd cycle
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b1, 4'hF, 32'h10 + 32'(4*i), 32'hA500_0000 + 32'(i),
           32'h0, 1'b0, 2);
    end
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b0, 4'hF, 32'h10 + 32'(4*i), 32'h0,
           32'hA500_0000 + 32'(i), 1'b0, 2);
    end
    idle(1);
    drain();

    // stall keeps the earned wait count
    stall[1] = 1'b1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        stall[1] = 1'b0;
      end
    join_none
    xact(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hA500_0000, 1'b0, 4);
    idle(1);

    // dropping req clears the wait count
    stall[1] = 1'b1;
    req[1]   = 1'b1;
    addr[1]  = 32'h14;
    repeat (2) @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    stall[1] = 1'b0;
    xact(1, 1'b0, 4'hF, 32'h14, 32'h0, 32'hA500_0001, 1'b0, 2);
    idle(1);
    drain();
    chk("rd_count_delay", rdc[1], 6);
    chk("wr_count_delay", wrc[1], 4);

    // RESP_LAT=3, MAX_OUTSTANDING=2: third read waits for a slot
    xact(2, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    idle(2);
    drain();
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    idle(2);
    drain();

    // reset with two reads in flight: both responses dropped
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    idle(2);
    rst[2] = 1'b1;
    sbq[2].delete();
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    drain();
    chk("rd_count_after_rst", rdc[2], 0);
    chk("wr_count_after_rst", wrc[2], 0);
    chk("err_count_after_rst", erc[2], 0);
    xact(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    idle(2);
    drain();
    chk("rd_count_post_rst", rdc[2], 1);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_empty_i%0d", i), 32'(sbq[i].size()), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
